// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: cmd encodings, register-file
// geometry, FSM state type and a one-hot index helper.
package issue_ctrl_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned CMD_W     = 7;

  localparam logic [CMD_W-1:0] CMD_NOP   = 7'h00;
  localparam logic [CMD_W-1:0] CMD_ADD   = 7'h01;
  localparam logic [CMD_W-1:0] CMD_SUB   = 7'h02;
  localparam logic [CMD_W-1:0] CMD_LOAD  = 7'h10;
  localparam logic [CMD_W-1:0] CMD_STORE = 7'h11;
  localparam logic [CMD_W-1:0] CMD_FENCE = 7'h7F;

  typedef enum logic {
    ST_RUN        = 1'b0,
    ST_FENCE_WAIT = 1'b1
  } issue_state_e;

  // One-hot mask selecting register idx
  function automatic logic [REG_COUNT-1:0] idx_mask(input logic [REG_IDX_W-1:0] idx);
    return REG_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-destination scoreboard. Tracks which registers await writeback,
// applies same-cycle retirement as a bypass, and flags RAW/WAW hazards.
module issue_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_set_en,
  input  logic [REG_IDX_W-1:0] i_set_idx,
  input  logic                 i_clr_en,
  input  logic [REG_IDX_W-1:0] i_clr_idx,
  input  logic [REG_IDX_W-1:0] i_rs1,
  input  logic [REG_IDX_W-1:0] i_rs2,
  input  logic [REG_IDX_W-1:0] i_rd,
  input  logic                 i_use_rs1,
  input  logic                 i_use_rs2,
  input  logic                 i_use_rd,
  output logic [REG_COUNT-1:0] o_busy_mask,
  output logic                 o_hazard
);

  logic [REG_COUNT-1:0] r_busy;
  logic [REG_COUNT-1:0] w_clr_mask;
  logic [REG_COUNT-1:0] w_set_mask;
  logic [REG_COUNT-1:0] w_eff_busy;
  logic [REG_COUNT-1:0] w_busy_next;

  // Set/clear masks, retirement bypass and hazard compare
  always_comb begin
    w_clr_mask  = i_clr_en ? idx_mask(i_clr_idx) : '0;
    w_set_mask  = (i_set_en && (i_set_idx != '0)) ? idx_mask(i_set_idx) : '0;
    w_eff_busy  = r_busy & ~w_clr_mask;
    // Set is applied after clear so a same-cycle issue on a retiring index keeps it busy
    w_busy_next = w_eff_busy | w_set_mask;
    w_busy_next[0] = 1'b0;
    o_hazard    = (i_use_rs1 && w_eff_busy[i_rs1]) ||
                  (i_use_rs2 && w_eff_busy[i_rs2]) ||
                  (i_use_rd  && w_eff_busy[i_rd]);
  end

  // Scoreboard register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  assign o_busy_mask = r_busy;

endmodule

// File: rtl/issue_ctrl.sv
// Issue/scheduling controller between decode and execute. Gates the decode
// handshake on hazards, memory back-pressure, the outstanding-load limit and
// fences; drives registered execute-stage enable/cmd/rd.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_LOADS = 4,
  parameter int unsigned CNT_W     = 4
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [CMD_W-1:0]     dec_cmd,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic                 dec_use_rs1,
  input  logic                 dec_use_rs2,
  input  logic                 dec_use_rd,
  input  logic                 dec_is_load,
  input  logic                 dec_is_store,
  input  logic                 mem_busy,
  input  logic                 ld_done,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_index,
  input  logic                 flush,
  output logic                 ex_enable,
  output logic [CMD_W-1:0]     ex_cmd,
  output logic [REG_IDX_W-1:0] ex_index_rd,
  output logic [REG_COUNT-1:0] busy_mask,
  output logic [CNT_W-1:0]     loads_outstanding
);

  localparam logic [CNT_W-1:0] LP_MAX_LOADS = CNT_W'(MAX_LOADS);

  issue_state_e         r_state;
  logic [CNT_W-1:0]     r_loads;
  logic                 r_ex_enable;
  logic [CMD_W-1:0]     r_ex_cmd;
  logic [REG_IDX_W-1:0] r_ex_rd;

  logic                 w_hazard;
  logic [REG_COUNT-1:0] w_busy_mask;
  logic                 w_mem_ok;
  logic                 w_load_ok;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_issue;
  logic                 w_fence_acc;
  logic                 w_ld_inc;
  logic                 w_ld_dec;

  issue_scoreboard u_scoreboard (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_set_en    (w_issue && dec_use_rd),
    .i_set_idx   (dec_rd),
    .i_clr_en    (wb_valid),
    .i_clr_idx   (wb_index),
    .i_rs1       (dec_rs1),
    .i_rs2       (dec_rs2),
    .i_rd        (dec_rd),
    .i_use_rs1   (dec_use_rs1),
    .i_use_rs2   (dec_use_rs2),
    .i_use_rd    (dec_use_rd),
    .o_busy_mask (w_busy_mask),
    .o_hazard    (w_hazard)
  );

  // Handshake qualification and issue classification
  always_comb begin
    w_mem_ok    = !((dec_is_load || dec_is_store) && mem_busy);
    w_load_ok   = !dec_is_load || (r_loads < LP_MAX_LOADS) || ld_done;
    w_ready     = (r_state == ST_RUN) && !flush && !w_hazard && w_mem_ok && w_load_ok;
    w_accept    = dec_valid && w_ready;
    w_issue     = w_accept && (dec_cmd != CMD_FENCE);
    w_fence_acc = w_accept && (dec_cmd == CMD_FENCE);
    w_ld_inc    = w_issue && dec_is_load;
    w_ld_dec    = ld_done && (r_loads != '0);
  end

  // Outstanding-load counter; a response at zero is ignored
  always_ff @(posedge clk) begin
    if (rst) begin
      r_loads <= '0;
    end else begin
      case ({w_ld_inc, w_ld_dec})
        2'b10:   r_loads <= r_loads + CNT_W'(1);
        2'b01:   r_loads <= r_loads - CNT_W'(1);
        default: r_loads <= r_loads;
      endcase
    end
  end

  // Run/fence FSM with registered execute-stage outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_ex_enable <= 1'b0;
      r_ex_cmd    <= '0;
      r_ex_rd     <= '0;
    end else begin
      r_ex_enable <= w_issue;
      if (w_issue) begin
        r_ex_cmd <= dec_cmd;
        r_ex_rd  <= dec_rd;
      end
      case (r_state)
        ST_RUN:        if (w_fence_acc) r_state <= ST_FENCE_WAIT;
        ST_FENCE_WAIT: if ((w_busy_mask == '0) && (r_loads == '0)) r_state <= ST_RUN;
        default:       r_state <= ST_RUN;
      endcase
    end
  end

  assign dec_ready         = w_ready;
  assign ex_enable         = r_ex_enable;
  assign ex_cmd            = r_ex_cmd;
  assign ex_index_rd       = r_ex_rd;
  assign busy_mask         = w_busy_mask;
  assign loads_outstanding = r_loads;

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus a randomized
// run compared against a behavioural model of the issue rules.
module tb_issue_ctrl;
  import issue_ctrl_pkg::*;

  localparam int MAXL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_ready;
  logic [6:0]  dec_cmd = '0;
  logic [4:0]  dec_rs1 = '0, dec_rs2 = '0, dec_rd = '0;
  logic        dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0, dec_use_rd = 1'b0;
  logic        dec_is_load = 1'b0, dec_is_store = 1'b0;
  logic        mem_busy = 1'b0, ld_done = 1'b0, wb_valid = 1'b0, flush = 1'b0;
  logic [4:0]  wb_index = '0;
  logic        ex_enable;
  logic [6:0]  ex_cmd;
  logic [4:0]  ex_index_rd;
  logic [31:0] busy_mask;
  logic [3:0]  loads_outstanding;

  int n_checks = 0;
  int n_err    = 0;

  // Behavioural model state
  bit         mbusy[32];
  int         mloads;
  bit         mfence;
  bit         m_en;
  logic [6:0] m_cmd;
  logic [4:0] m_rd;

  issue_ctrl #(.MAX_LOADS(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_cmd(dec_cmd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_use_rd(dec_use_rd),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store), .mem_busy(mem_busy),
    .ld_done(ld_done), .wb_valid(wb_valid), .wb_index(wb_index), .flush(flush),
    .ex_enable(ex_enable), .ex_cmd(ex_cmd), .ex_index_rd(ex_index_rd),
    .busy_mask(busy_mask), .loads_outstanding(loads_outstanding)
  );

  always #5 clk = ~clk;

  function automatic bit m_pending(input logic [4:0] r);
    return (r != 0) && mbusy[r] && !(wb_valid && (wb_index == r));
  endfunction

  function automatic bit m_ready();
    if (mfence || flush) return 1'b0;
    if (dec_use_rs1 && m_pending(dec_rs1)) return 1'b0;
    if (dec_use_rs2 && m_pending(dec_rs2)) return 1'b0;
    if (dec_use_rd  && m_pending(dec_rd))  return 1'b0;
    if ((dec_is_load || dec_is_store) && mem_busy) return 1'b0;
    if (dec_is_load && !(mloads < MAXL || ld_done)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = mbusy[i];
    return m;
  endfunction

  task automatic model_edge();
    bit acc, iss, drained;
    int old;
    if (rst) begin
      for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
      mloads = 0; mfence = 1'b0; m_en = 1'b0; m_cmd = '0; m_rd = '0;
      return;
    end
    acc     = dec_valid && m_ready();
    iss     = acc && (dec_cmd != CMD_FENCE);
    drained = (m_mask() == 0) && (mloads == 0);
    old     = mloads;
    if (wb_valid) mbusy[wb_index] = 1'b0;
    if (iss && dec_use_rd && dec_rd != 0) mbusy[dec_rd] = 1'b1;
    mloads = old + ((iss && dec_is_load) ? 1 : 0) - ((ld_done && old > 0) ? 1 : 0);
    if (mfence && drained) mfence = 1'b0;
    else if (acc && dec_cmd == CMD_FENCE) mfence = 1'b1;
    m_en = iss;
    if (iss) begin m_cmd = dec_cmd; m_rd = dec_rd; end
  endtask

  // Advance one clock, keep the model in step, settle outputs
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    dec_valid = 0; dec_cmd = '0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; dec_use_rd = 0; dec_is_load = 0; dec_is_store = 0;
    mem_busy = 0; ld_done = 0; wb_valid = 0; wb_index = '0; flush = 0;
  endtask

  task automatic put(input logic [6:0] c, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [4:0] d, input bit u1, input bit u2, input bit ud);
    dec_valid = 1; dec_cmd = c; dec_rs1 = s1; dec_rs2 = s2; dec_rd = d;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_use_rd = ud;
    dec_is_load = (c == CMD_LOAD); dec_is_store = (c == CMD_STORE);
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
    n_checks++; if (ex_enable !== 1'b0) begin n_err++; $display("FAIL reset_en got %0h exp 0", ex_enable); end
    n_checks++; if (ex_cmd !== 7'h0) begin n_err++; $display("FAIL reset_cmd got %0h exp 0", ex_cmd); end
    n_checks++; if (ex_index_rd !== 5'h0) begin n_err++; $display("FAIL reset_rd got %0h exp 0", ex_index_rd); end
    n_checks++; if (busy_mask !== 32'h0) begin n_err++; $display("FAIL reset_busy got %0h exp 0", busy_mask); end
    n_checks++; if (loads_outstanding !== 4'h0) begin n_err++; $display("FAIL reset_loads got %0h exp 0", loads_outstanding); end
    put(CMD_ADD, 0, 0, 1, 0, 0, 1); #2;
    n_checks++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0h exp 1", dec_ready); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      put(CMD_ADD, 0, 0, 5'(i), 1, 1, 1); #2;
      n_checks++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d got %0h exp 1", i, dec_ready); end
      tick();
      n_checks++; if (ex_enable !== 1'b1 || ex_index_rd !== 5'(i) || ex_cmd !== CMD_ADD) begin
        n_err++; $display("FAIL b2b_ex%0d got en=%0h rd=%0h cmd=%0h exp en=1 rd=%0h cmd=%0h", i, ex_enable, ex_index_rd, ex_cmd, i, CMD_ADD);
      end
    end
    idle(); tick();
    n_checks++; if (ex_enable !== 1'b0) begin n_err++; $display("FAIL b2b_en_drop got %0h exp 0", ex_enable); end
    n_checks++; if (ex_index_rd !== 5'd3) begin n_err++; $display("FAIL b2b_rd_hold got %0h exp 3", ex_index_rd); end
    n_checks++; if (busy_mask !== 32'h0000000E) begin n_err++; $display("FAIL b2b_busy got %0h exp e", busy_mask); end
  endtask

  task automatic test_raw();
    do_reset();
    put(CMD_ADD, 0, 0, 5, 0, 0, 1); tick();
    put(CMD_SUB, 5, 0, 5, 1, 0, 1); #2;
    n_checks++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall got %0h exp 0", dec_ready); end
    tick();
    n_checks++; if (ex_enable !== 1'b0) begin n_err++; $display("FAIL raw_noissue got %0h exp 0", ex_enable); end
    wb_valid = 1; wb_index = 5; #2;
    n_checks++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL raw_bypass got %0h exp 1", dec_ready); end
    tick();
    n_checks++; if (ex_enable !== 1'b1 || ex_cmd !== CMD_SUB) begin n_err++; $display("FAIL raw_issue got en=%0h cmd=%0h exp en=1 cmd=%0h", ex_enable, ex_cmd, CMD_SUB); end
    n_checks++; if (busy_mask !== 32'h00000020) begin n_err++; $display("FAIL raw_busy got %0h exp 20", busy_mask); end
    idle();
  endtask

  task automatic test_loads();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(CMD_LOAD, 0, 0, 5'(6 + i), 0, 0, 1); #2;
      n_checks++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL load_ready%0d got %0h exp 1", i, dec_ready); end
      tick();
    end
    n_checks++; if (loads_outstanding !== 4'd4) begin n_err++; $display("FAIL load_count got %0h exp 4", loads_outstanding); end
    put(CMD_LOAD, 0, 0, 10, 0, 0, 1); #2;
    n_checks++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL load_limit got %0h exp 0", dec_ready); end
    tick();
    ld_done = 1; #2;
    n_checks++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL load_done_admit got %0h exp 1", dec_ready); end
    tick();
    n_checks++; if (loads_outstanding !== 4'd4 || ex_enable !== 1'b1) begin
      n_err++; $display("FAIL load_swap got cnt=%0h en=%0h exp cnt=4 en=1", loads_outstanding, ex_enable);
    end
    n_checks++; if (busy_mask !== 32'h000007C0) begin n_err++; $display("FAIL load_busy got %0h exp 7c0", busy_mask); end
    idle();
  endtask

  task automatic test_fence();
    do_reset();
    put(CMD_LOAD, 0, 0, 6, 0, 0, 1); tick();
    idle(); tick();
    n_checks++; if (busy_mask !== 32'h40 || loads_outstanding !== 4'd1) begin
      n_err++; $display("FAIL fence_pre got busy=%0h cnt=%0h exp busy=40 cnt=1", busy_mask, loads_outstanding);
    end
    put(CMD_FENCE, 0, 0, 0, 0, 0, 0); #2;
    n_checks++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL fence_accept got %0h exp 1", dec_ready); end
    tick();
    n_checks++; if (ex_enable !== 1'b0) begin n_err++; $display("FAIL fence_noex got %0h exp 0", ex_enable); end
    put(CMD_ADD, 0, 0, 1, 0, 0, 1); #2;
    n_checks++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL fence_block got %0h exp 0", dec_ready); end
    tick();
    wb_valid = 1; wb_index = 6; ld_done = 1; #2;
    n_checks++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL fence_block2 got %0h exp 0", dec_ready); end
    tick();
    n_checks++; if (busy_mask !== 32'h0 || loads_outstanding !== 4'd0 || ex_enable !== 1'b0) begin
      n_err++; $display("FAIL fence_drain got busy=%0h cnt=%0h en=%0h exp 0 0 0", busy_mask, loads_outstanding, ex_enable);
    end
    wb_valid = 0; ld_done = 0; #2;
    n_checks++; if (dec_ready !== 1'b0) begin n_err++; $display("FAIL fence_exit_edge got %0h exp 0", dec_ready); end
    tick(); #2;
    n_checks++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL fence_run got %0h exp 1", dec_ready); end
    tick();
    n_checks++; if (ex_enable !== 1'b1 || ex_index_rd !== 5'd1) begin
      n_err++; $display("FAIL fence_post_issue got en=%0h rd=%0h exp en=1 rd=1", ex_enable, ex_index_rd);
    end
    idle();
  endtask

  task automatic test_setclr();
    do_reset();
    put(CMD_ADD, 0, 0, 7, 0, 0, 1); tick();
    wb_valid = 1; wb_index = 7; #2;
    n_checks++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL setclr_ready got %0h exp 1", dec_ready); end
    tick();
    n_checks++; if (busy_mask !== 32'h00000080) begin n_err++; $display("FAIL setclr_busy got %0h exp 80", busy_mask); end
    idle();
  endtask

  task automatic test_reset_fence();
    do_reset();
    put(CMD_LOAD, 0, 0, 8, 0, 0, 1); tick();
    put(CMD_LOAD, 0, 0, 0, 0, 0, 0); tick();
    put(CMD_FENCE, 0, 0, 0, 0, 0, 0); tick();
    n_checks++; if (busy_mask !== 32'h100 || loads_outstanding !== 4'd2) begin
      n_err++; $display("FAIL rstf_pre got busy=%0h cnt=%0h exp busy=100 cnt=2", busy_mask, loads_outstanding);
    end
    idle(); rst = 1; tick(); rst = 0;
    n_checks++; if (busy_mask !== 32'h0 || loads_outstanding !== 4'd0 || ex_enable !== 1'b0) begin
      n_err++; $display("FAIL rstf_clear got busy=%0h cnt=%0h en=%0h exp 0 0 0", busy_mask, loads_outstanding, ex_enable);
    end
    put(CMD_ADD, 1, 2, 3, 1, 1, 1); #2;
    n_checks++; if (dec_ready !== 1'b1) begin n_err++; $display("FAIL rstf_ready got %0h exp 1", dec_ready); end
    tick(); idle();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      r = int'($urandom_range(0, 19));
      if (r == 0)      put(CMD_FENCE, 0, 0, 0, 0, 0, 0);
      else if (r <= 5) put(CMD_LOAD, 5'($urandom_range(0, 7)), 0, 5'($urandom_range(0, 7)), 1, 0, 1);
      else if (r <= 8) put(CMD_STORE, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 0, 1, 1, 0);
      else put((r & 1) ? CMD_ADD : CMD_SUB, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1);
      dec_valid = ($urandom_range(0, 9) < 7);
      mem_busy  = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      ld_done   = ($urandom_range(0, 3) == 0);
      wb_valid  = ($urandom_range(0, 9) < 4);
      wb_index  = 5'($urandom_range(0, 7));
      #2;
      n_checks++; if (dec_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready@%0d got %0h exp %0h", n, dec_ready, m_ready()); end
      tick();
      n_checks++; if (ex_enable !== m_en) begin n_err++; $display("FAIL rnd_en@%0d got %0h exp %0h", n, ex_enable, m_en); end
      n_checks++; if (ex_cmd !== m_cmd || ex_index_rd !== m_rd) begin
        n_err++; $display("FAIL rnd_ex@%0d got cmd=%0h rd=%0h exp cmd=%0h rd=%0h", n, ex_cmd, ex_index_rd, m_cmd, m_rd);
      end
      n_checks++; if (busy_mask !== m_mask()) begin n_err++; $display("FAIL rnd_busy@%0d got %0h exp %0h", n, busy_mask, m_mask()); end
      n_checks++; if (int'(loads_outstanding) != mloads) begin n_err++; $display("FAIL rnd_loads@%0d got %0d exp %0d", n, loads_outstanding, mloads); end
    end
    rst = 0; idle();
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_back_to_back();
    test_raw();
    test_loads();
    test_fence();
    test_setclr();
    test_reset_fence();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Issue/scheduling controller in front of the execute stage. Accepts decoded instructions over a valid/ready handshake and tracks pending destination registers in a 32-entry scoreboard. Stalls on RAW/WAW hazards, data-memory back-pressure and the outstanding-load limit, and drives the execute stage's enable, cmd and index_rd. Sits between decode and execute; retirement comes back from the writeback stage.

Parameters:
MAX_LOADS, 4, maximum loads issued but not yet answered (ld_done); range 1..15
CNT_W, 4, width of loads_outstanding; must hold MAX_LOADS

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
dec_valid  in  1  decode offers an instruction
dec_ready  out  1  controller accepts; transfer when dec_valid && dec_ready
dec_cmd  in  7  operation code, same encoding as execute cmd
dec_rs1, dec_rs2, dec_rd  in  5 each  register indices
dec_use_rs1, dec_use_rs2, dec_use_rd  in  1 each  operand/destination actually used
dec_is_load, dec_is_store  in  1 each  memory-access class
mem_busy  in  1  data memory cannot accept a new access this cycle
ld_done  in  1  one load response returned
wb_valid  in  1  writeback retires a register
wb_index  in  5  register being retired
flush  in  1  discard the instruction offered this cycle
ex_enable  out  1  registered; execute consumes ex_cmd this cycle
ex_cmd  out  7  registered cmd to execute
ex_index_rd  out  5  registered destination index to execute
busy_mask  out  32  scoreboard, bit i = register i pending
loads_outstanding  out  CNT_W  current outstanding-load count

Behaviour:
- Reset (rst=1 at clk edge): state=RUN, busy_mask=0, loads_outstanding=0, ex_enable=0, ex_cmd=0, ex_index_rd=0. A reset asserted mid-stall or mid-fence aborts it; no pending state survives.
- dec_ready is combinational and is 1 only if all of the following hold:
  - state=RUN and flush=0;
  - no RAW: not (use_rs1 && eff_busy[rs1]) and not (use_rs2 && eff_busy[rs2]);
  - no WAW: not (use_rd && eff_busy[rd]);
  - for loads/stores, mem_busy=0;
  - for loads, loads_outstanding < MAX_LOADS, or ld_done=1 this cycle.
- eff_busy = busy_mask with bit wb_index cleared when wb_valid=1 (same-cycle retirement bypass). Bit 0 is always 0; index 0 never causes a hazard.
- Issue (handshake, cmd != cmd_fence): next cycle ex_enable=1, ex_cmd=dec_cmd, ex_index_rd=dec_rd. busy[dec_rd] is set if use_rd && rd!=0. With no issue, ex_enable=0 next cycle and ex_cmd/ex_index_rd hold their values.
- Retire: wb_valid clears busy[wb_index] next cycle. Retiring a non-busy bit has no effect. Same-cycle issue-set and retire-clear on the same index: set wins.
- Load counter: +1 on load issue, -1 on ld_done; both in the same cycle leaves it unchanged. ld_done at 0 is ignored and the counter saturates at 0. It never exceeds MAX_LOADS.
- Store: not counted, sets no busy bit.
- Fence (cmd_fence accepted): ex_enable stays 0 and state goes to FENCE_WAIT. dec_ready=0 until busy_mask==0 and loads_outstanding==0 at a clock edge; then state=RUN next cycle, and the first post-fence issue is possible that cycle.
- flush: forces dec_ready=0 and produces no issue that cycle. It does not touch the scoreboard, the counter or state; in-flight ops still retire normally.
- Throughput: one issue per cycle with no hazards. Issue-to-ex_enable latency is 1 cycle.

Decomposition:
- Shared define file holds the cmd encodings, including the new cmd_fence, plus the register-index width (5) and the register count (32).
- Natural sub-module: issue_scoreboard. It owns busy_mask set/clear/bypass and the hazard compare, and returns a single hazard bit.
- FSM, load counter and execute output registers stay in issue_ctrl.

Test Plan:
- Back-to-back independent adds (rd=1,2,3, sources x0) on 3 consecutive valid cycles -> dec_ready=1 each cycle; ex_enable=1 for 3 cycles starting one cycle later; busy_mask=0x0000000E.
- RAW: add rd=5, then add rs1=5 -> second held with dec_ready=0; wb_valid=1, wb_index=5 in cycle N -> second issues in cycle N via the bypass; busy[5] is set again by the second op.
- Loads: MAX_LOADS=4; issue 4 loads (rd=6..9) -> loads_outstanding=4, 5th load stalled. ld_done in the same cycle as the 5th load is presented -> it issues and the count stays 4.
- Fence: busy_mask=0x00000040, loads=1, then fence -> dec_ready=0. After wb_index=6 and ld_done, both reach 0 -> RUN; next add issues; fence itself never raises ex_enable.
- Simultaneous set/clear: issue rd=7 with wb_valid=1, wb_index=7 in the same cycle -> busy[7]=1 afterwards.
- Reset mid-FENCE_WAIT with busy_mask=0x00000100, loads=2 -> next cycle busy_mask=0, loads_outstanding=0, ex_enable=0, dec_ready=1 for an independent add.
